match_event_fifo: RTL
=====================

// Module: match_event_fifo
// PURPOSE
//   Downstream consumer of the 1/2/3 sequence detector's 1-bit match flag (ans).
//   Converts each match into one timestamped event and buffers the events in a small FWFT FIFO.
//   Keeps a saturating total-match counter and a sticky overflow flag.
//   Lets a slow reader or testbench drain match times without missing bursts.
// PARAMETERS
//   DEPTH  8  FIFO entries; power of two, >= 2
//   TS_W   8  width of free-running cycle timestamp (wraps modulo 2^TS_W)
//   CNT_W  8  width of saturating match counter
// PORTS
//   clk      in   1                  rising-edge clock, shared with the detector
//   rst_n    in   1                  asynchronous active-low reset
//   ans      in   1                  match flag from detector; may stay high several cycles
//   clr      in   1                  synchronous clear of FIFO, counter, flags, timestamp
//   rd_en    in   1                  pop head entry; ignored when empty
//   rd_data  out  TS_W               head entry timestamp; valid when empty=0
//   empty    out  1                  FIFO holds no entries
//   full     out  1                  FIFO holds DEPTH entries
//   level    out  $clog2(DEPTH)+1    current occupancy, 0..DEPTH
//   count    out  CNT_W              total events detected since reset/clr; saturates at 2^CNT_W-1
//   overflow out  1                  sticky; set when an event is dropped because FIFO is full
// BEHAVIOUR
// - Reset (rst_n=0, async, immediate): ts=0, ans_d=0, wr/rd pointers=0.
//   Reset output values: level=0, empty=1, full=0, count=0, overflow=0, rd_data=0.
// - Timestamp counter:
//   - ts increments by 1 every clock; wraps 2^TS_W-1 -> 0.
//   - clr forces ts=0 on the next edge.
// - Event detection:
//   - ans_d registers ans every cycle, including clr cycles.
//   - An event occurs in a cycle where ans=1 and ans_d=0 (rising edge).
//   - A high level held N cycles = exactly one event.
//   - Pushed value = ts value in the event cycle, before that edge's increment.
// - Push/pop, evaluated each rising edge:
//   - push = event & ~clr; pop = rd_en & ~empty & ~clr.
//   - push & ~full -> write at wr_ptr, wr_ptr+1.
//   - push & full & ~pop -> entry dropped, overflow<=1; FIFO contents unchanged.
//   - push & full & pop -> both performed; level stays DEPTH; no overflow.
//   - push & empty -> entry visible next cycle: empty=0, rd_data=stamp (1-cycle latency).
//   - pop -> head advances; rd_data shows the next entry on the following cycle.
//   - Pointers are $clog2(DEPTH)+1 bits and wrap naturally.
//   - full and empty are derived from the pointers; level = wr_ptr - rd_ptr.
// - Match counter:
//   - count increments on every event, including dropped ones, unless clr is high.
//   - Saturates at all-ones; never wraps.
// - clr (synchronous):
//   - Highest priority. Empties FIFO and zeroes count, overflow and ts on the next edge.
//   - An event in the clr cycle is discarded.
//   - Because ans_d still samples, an ans held high across clr release is not re-counted.
// - rd_data:
//   - FWFT: always the memory word at rd_ptr.
//   - Don't-care while empty, except at reset, where it is 0.
// - All outputs are registered or decoded from registers only; no combinational path from any input.
// TESTING
//   T1 Single pulse: release rst_n, drive ans=1 in the ts=5 cycle only
//      -> next cycle empty=0, rd_data=5, level=1, count=1.
//   T2 Held match: ans=1 for 3 cycles starting at ts=10
//      -> exactly one entry, rd_data=10, count increments by 1.
//   T3 Overflow: 9 single-cycle pulses at ts=20,22,...,36, no reads
//      -> full=1 after 8th, overflow=1, count=9.
//      -> 8 pops return 20..34 in order, then empty=1.
//   T4 Full with push+pop: FIFO full, pulse ans in the same cycle as rd_en=1
//      -> level stays 8, overflow stays 0, new stamp becomes tail entry.
//   T5 Wrap/saturate: pulse at ts=255 and ts=1 (after wrap) -> entries 255 then 1.
//      300 pulses -> count=255.
//      clr=1 one cycle -> count=0, empty=1, overflow=0, ts restarts at 0.
//   T6 Async reset mid-operation: assert rst_n=0 between edges with level=3
//      -> empty=1, level=0, count=0 before the next edge.
//      -> after release, a held ans=1 yields one event.

Source files
------------

// File: rtl/match_event_fifo.sv
// match_event_fifo: turns each rising edge of the detector match flag into a
// timestamped event, buffers events in a first-word-fall-through FIFO, and
// keeps a saturating match counter plus a sticky overflow flag.
module match_event_fifo #(
    parameter int DEPTH = 8,
    parameter int TS_W  = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ans,
    input  logic                     clr,
    input  logic                     rd_en,
    output logic [TS_W-1:0]          rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [TS_W-1:0] ts;
    logic            ans_d;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [TS_W-1:0] mem [DEPTH];

    logic event_hit;
    logic push;
    logic pop;
    logic do_write;
    logic drop;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) return v;
        return v + CNT_W'(1);
    endfunction

    // A held match level produces a single event on its first cycle.
    assign event_hit = ans & ~ans_d;
    assign push      = event_hit & ~clr;
    assign pop       = rd_en & ~empty & ~clr;
    // When full, a simultaneous pop frees the head slot, which the new entry reuses.
    assign do_write  = push & (~full | pop);
    assign drop      = push & full & ~pop;

    // Extra pointer MSB distinguishes full from empty when the indices coincide.
    assign level   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Free-running timestamp and match-flag history; ans_d samples even during clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts    <= '0;
            ans_d <= 1'b0;
        end else begin
            ans_d <= ans;
            if (clr) ts <= '0;
            else     ts <= ts + TS_W'(1);
        end
    end

    // FIFO pointers, match counter and sticky overflow; clr overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_write)  wr_ptr <= wr_ptr + PW'(1);
            if (pop)       rd_ptr <= rd_ptr + PW'(1);
            if (event_hit) count  <= sat_inc(count);
            if (drop)      overflow <= 1'b1;
        end
    end

    // Event storage; cleared at reset so the head word reads as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_write) begin
            mem[wr_ptr[AW-1:0]] <= ts;
        end
    end

endmodule
